// File: rtl/debounce_pkg.sv
// Shared types and parameter defaults for the push-button debounce scheduler.
package debounce_pkg;

    typedef enum logic {IDLE, SCAN} scan_state_t;

    localparam int unsigned DEPTH_DEF    = 10;
    localparam int unsigned TICK_DIV_DEF = 100000;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle sample tick every TICK_DIV clocks.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = debounce_pkg::TICK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    // Count while enabled; tick is registered so it is high exactly while cnt sits at TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (!reset || !en) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            if (cnt == CW'(TICK_DIV - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            tick <= (cnt == CW'(TICK_DIV - 2));
        end
    end

endmodule

// File: rtl/debounce_scheduler.sv
// Time-multiplexed debouncer: one shared history-update unit walks all buttons after each sample tick.
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter int unsigned N_BTN    = 4,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N_BTN-1:0] btn,
    output logic             tick,
    output logic [N_BTN-1:0] db,
    output logic [N_BTN-1:0] rise,
    output logic [N_BTN-1:0] fall,
    output logic             busy
);

    localparam int unsigned IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    scan_state_t      state, state_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [N_BTN-1:0] snap;
    logic [DEPTH-1:0] hist [N_BTN];
    logic [DEPTH-1:0] hist_new_c;
    logic             scan_c;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (tick)
    );

    assign busy = (state == SCAN);

    // Scan sequencing and the shifted history for the button currently addressed.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        scan_c     = (state == SCAN);
        hist_new_c = {snap[idx], hist[idx][DEPTH-1:1]};
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                end
            end
            SCAN: begin
                if (idx == IW'(N_BTN - 1)) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // FSM state and scan index registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Coherent snapshot of all buttons; a tick arriving mid-scan is ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            snap <= '0;
        end else if (tick && (state == IDLE)) begin
            snap <= btn;
        end
    end

    // History shift, hysteretic level update and single-cycle edge pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(N_BTN); i++) begin
                hist[i] <= '0;
            end
            db   <= '0;
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= '0;
            fall <= '0;
            if (scan_c) begin
                hist[idx] <= hist_new_c;
                if ((&hist_new_c) && !db[idx]) begin
                    db[idx]   <= 1'b1;
                    rise[idx] <= 1'b1;
                end else if (!(|hist_new_c) && db[idx]) begin
                    db[idx]   <= 1'b0;
                    fall[idx] <= 1'b1;
                end
            end
        end
    end

endmodule
